core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port imem_req, output, 1 bit: instruction fetch request.
REQ-005 SHALL have port imem_addr, output, 32 bits: fetch address, equal to pc.
REQ-006 SHALL have port imem_valid, input, 1 bit: imem_rdata valid this cycle.
REQ-007 SHALL have port imem_rdata, input, 32 bits: fetched instruction.
REQ-008 SHALL have port inst, output, 32 bits: instruction register, driven to the ALU decoder.
REQ-009 SHALL have port imm, input, 32 bits: branch offset from the decoder.
REQ-010 SHALL have port alu_cmp, input, 1 bit: branch condition result from the ALU.
REQ-011 SHALL have port dmem_req, output, 1 bit: data memory request.
REQ-012 SHALL have port dmem_we, output, 1 bit: data memory write, 1 for STORE.
REQ-013 SHALL have port dmem_valid, input, 1 bit: data access complete.
REQ-014 SHALL have port rf_we, output, 1 bit: register-file write strobe.
REQ-015 SHALL have port illegal, output, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-016 SHALL have port instret, output, 32 bits: retired-instruction counter.
REQ-017 SHALL have port state, output, 3 bits: current FSM state, for debug.

Function
REQ-018 SHALL implement the FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3 and WB=4; encodings 5-7 SHALL go to FETCH on the next edge.
REQ-019 SHALL drive outputs Moore-style from state: imem_req=1 only in FETCH; dmem_req=1 only in MEM; rf_we=1 only in WB.
REQ-020 SHALL behave as follows in FETCH: hold imem_addr=pc stable until imem_valid; on imem_valid, load inst<=imem_rdata and go to DECODE.
REQ-021 SHALL spend exactly one cycle in DECODE so the registered decoder outputs (imm, alu_op) settle, then go to EXEC.
REQ-022 SHALL take the EXEC exit selected by the opcode inst[6:0], as listed in REQ-023 to REQ-026.
REQ-023 SHALL, for BRANCH (1100011), set pc<=pc+imm if alu_cmp=1, else pc<=pc+4, then go to FETCH.
REQ-024 SHALL, for LOAD (0000011) or STORE (0100011), go to MEM.
REQ-025 SHALL, for OP (0110011) or OP_IMM (0010011), go to WB.
REQ-026 SHALL, for any other opcode, pulse illegal for one cycle, set pc<=pc+4, and go to FETCH.
REQ-027 SHALL behave as follows in MEM: dmem_we=(opcode==STORE); wait for dmem_valid; then STORE sets pc<=pc+4 and goes to FETCH, and LOAD goes to WB.
REQ-028 SHALL behave as follows in WB: rf_we=1 for one cycle, pc<=pc+4, next state FETCH.
REQ-029 SHALL perform all PC arithmetic modulo 2^32 (wraps at 32'hFFFF_FFFC+4 -> 0); branch targets are used unmodified, with no alignment check.
REQ-030 SHALL increment instret by 1, modulo 2^32, on the edge each instruction leaves the FSM (BRANCH/illegal EXEC exit, STORE MEM exit, WB exit).
REQ-031 SHALL give a minimum latency from FETCH entry to next FETCH entry, with zero-wait memories, of: OP/OP_IMM 4 cycles, BRANCH 3, STORE 4, LOAD 5.
REQ-032 SHALL ignore imem_valid outside FETCH and dmem_valid outside MEM.
REQ-033 SHALL keep inst unchanged except on the FETCH accept edge.

Reset
REQ-034 SHALL, when reset=1 at a clock edge, set state=FETCH, pc=RESET_PC, inst=0, instret=0 and illegal=0, overriding any other event that cycle.
REQ-035 SHALL abandon a pending fetch, memory access or writeback on reset mid-operation, with no rf_we, no instret increment and no pc update.
REQ-036 SHALL present imem_req=1 and imem_addr=RESET_PC in the first cycle after reset deasserts.

Verification
REQ-037 SHALL be verified for OP: reset, then imem_rdata=32'h002081B3 (add) with immediate imem_valid -> rf_we pulses in cycle 4, pc=4, instret=1.
REQ-038 SHALL be verified for BRANCH taken and not taken: beq with imm=32'h10 at pc=8; alu_cmp=1 -> pc=0x18; alu_cmp=0 -> pc=0x0C; 3 cycles each, no rf_we.
REQ-039 SHALL be verified for LOAD with wait states: dmem_valid delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, then one WB cycle, pc+=4.
REQ-040 SHALL be verified for STORE: dmem_we=1 during MEM, no rf_we, pc+=4, instret+=1.
REQ-041 SHALL be verified for an illegal opcode: opcode 1111111 -> illegal high exactly 1 cycle, pc+=4, instret+=1.
REQ-042 SHALL be verified for reset mid-MEM: reset asserted during MEM -> next cycle state=0, pc=RESET_PC, instret=0, with no rf_we observed.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; 3-5 cycles per instruction with zero-wait memories.
// Backpressure: FETCH holds the request until imem_valid, MEM holds it until dmem_valid.
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    input  logic [31:0] imm,
    input  logic        alu_cmp,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_valid,
    output logic        rf_we,
    output logic        illegal,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] instret_q;
    logic        illegal_q;
    logic        imem_req_q;
    logic        dmem_req_q;
    logic        dmem_we_q;
    logic        rf_we_q;
    logic [6:0]  opcode;

    assign opcode = inst_q[6:0];

    // Strobes are registered alongside the state so they always line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            instret_q  <= '0;
            illegal_q  <= 1'b0;
            imem_req_q <= 1'b1;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            rf_we_q   <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (imem_valid) begin
                        inst_q     <= imem_rdata;
                        state_q    <= S_DECODE;
                        imem_req_q <= 1'b0;
                    end
                end
                S_DECODE: begin
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    case (opcode)
                        OPC_BRANCH: begin
                            pc_q       <= alu_cmp ? (pc_q + imm) : (pc_q + 32'd4);
                            state_q    <= S_FETCH;
                            imem_req_q <= 1'b1;
                            instret_q  <= instret_q + 32'd1;
                        end
                        OPC_LOAD, OPC_STORE: begin
                            state_q    <= S_MEM;
                            dmem_req_q <= 1'b1;
                            dmem_we_q  <= (opcode == OPC_STORE);
                        end
                        OPC_OP, OPC_OP_IMM: begin
                            state_q <= S_WB;
                            rf_we_q <= 1'b1;
                        end
                        default: begin
                            illegal_q  <= 1'b1;
                            pc_q       <= pc_q + 32'd4;
                            state_q    <= S_FETCH;
                            imem_req_q <= 1'b1;
                            instret_q  <= instret_q + 32'd1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_valid) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (opcode == OPC_STORE) begin
                            pc_q       <= pc_q + 32'd4;
                            state_q    <= S_FETCH;
                            imem_req_q <= 1'b1;
                            instret_q  <= instret_q + 32'd1;
                        end else begin
                            state_q <= S_WB;
                            rf_we_q <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    pc_q       <= pc_q + 32'd4;
                    state_q    <= S_FETCH;
                    imem_req_q <= 1'b1;
                    instret_q  <= instret_q + 32'd1;
                end
                default: begin
                    state_q    <= S_FETCH;
                    imem_req_q <= 1'b1;
                    dmem_req_q <= 1'b0;
                    dmem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign inst      = inst_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign rf_we     = rf_we_q;
    assign illegal   = illegal_q;
    assign instret   = instret_q;
    assign state     = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: stimulus queues one expected record per
// instruction; the monitor closes an interval at every FETCH entry and compares.
module tb_core_sequencer;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] imm;
    logic        alu_cmp;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_valid;
    logic        rf_we;
    logic        illegal;
    logic [31:0] instret;
    logic [2:0]  state;

    core_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .imm        (imm),
        .alu_cmp    (alu_cmp),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_valid (dmem_valid),
        .rf_we      (rf_we),
        .illegal    (illegal),
        .instret    (instret),
        .state      (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] ret;
        int          cyc;
        int          rfwe;
        int          dreq;
        int          dwe;
        int          ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: samples 2 time units after each rising edge.
    int          m_cyc, m_rfwe, m_dreq, m_dwe, m_ill;
    logic [31:0] m_inst;
    logic [2:0]  m_prev;
    exp_t        m_e;

    always @(posedge clock) begin
        #2;
        if (reset) begin
            m_cyc  = 1;
            m_rfwe = rf_we ? 1 : 0;
            m_dreq = dmem_req ? 1 : 0;
            m_dwe  = dmem_we ? 1 : 0;
            m_ill  = 0;
            m_inst = '0;
            m_prev = 3'd0;
        end else if (state == 3'd0 && m_prev != 3'd0) begin
            m_ill += illegal ? 1 : 0;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire actual=%0h expected=none", imem_addr);
            end else begin
                m_e = q.pop_front();
                chk("inst", m_inst, m_e.inst);
                chk("next_pc", imem_addr, m_e.pc);
                chk("instret", instret, m_e.ret);
                chk("cycles", 32'(m_cyc), 32'(m_e.cyc));
                chk("rf_we_cycles", 32'(m_rfwe), 32'(m_e.rfwe));
                chk("dmem_req_cycles", 32'(m_dreq), 32'(m_e.dreq));
                chk("dmem_we_cycles", 32'(m_dwe), 32'(m_e.dwe));
                chk("illegal_cycles", 32'(m_ill), 32'(m_e.ill));
            end
            m_cyc  = 1;
            m_rfwe = rf_we ? 1 : 0;
            m_dreq = dmem_req ? 1 : 0;
            m_dwe  = dmem_we ? 1 : 0;
            m_ill  = 0;
        end else begin
            m_cyc++;
            m_rfwe += rf_we ? 1 : 0;
            m_dreq += dmem_req ? 1 : 0;
            m_dwe  += dmem_we ? 1 : 0;
            m_ill  += illegal ? 1 : 0;
            if (state != 3'd0) m_inst = inst;
        end
        m_prev = state;
    end

    // Called at a falling edge with the DUT in FETCH; returns at the next FETCH entry.
    task automatic issue(input logic [31:0] ins, input logic [31:0] offs, input logic cmp,
                         input int iw, input int dw, input logic noise,
                         input logic [31:0] e_pc, input logic [31:0] e_ret,
                         input int e_cyc, input int e_rfwe, input int e_dreq,
                         input int e_dwe, input int e_ill);
        exp_t e;
        bit   done;
        int   mcnt;
        e.inst = ins;   e.pc = e_pc;     e.ret = e_ret;  e.cyc = e_cyc;
        e.rfwe = e_rfwe; e.dreq = e_dreq; e.dwe = e_dwe; e.ill = e_ill;
        q.push_back(e);
        imm     = offs;
        alu_cmp = cmp;
        for (int i = 0; i < iw; i++) begin
            imem_valid = 1'b0;
            imem_rdata = JUNK;
            @(negedge clock);
        end
        imem_valid = 1'b1;
        imem_rdata = ins;
        @(negedge clock);
        done = 1'b0;
        mcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (state == 3'd0) begin
                done = 1'b1;
                break;
            end
            imem_valid = noise;
            imem_rdata = JUNK;
            if (state == 3'd3) begin
                dmem_valid = (mcnt >= dw);
                mcnt++;
            end else begin
                dmem_valid = noise;
            end
            @(negedge clock);
        end
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout actual=state%0d expected=state0", state);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_imem_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_imem_addr"}, imem_addr, 32'h0);
        chk({tag, "_inst"}, inst, 32'h0);
        chk({tag, "_instret"}, instret, 32'h0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        chk({tag, "_rf_we"}, 32'(rf_we), 32'd0);
        chk({tag, "_dmem_req"}, 32'(dmem_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int  rfcnt;
    bit  got_mem;

    initial begin
        reset      = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = '0;
        imm        = '0;
        alu_cmp    = 1'b0;
        dmem_valid = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;

        //     inst          imm           cmp  iw dw noise  next_pc        instret   cyc rf dr dw il
        issue(32'h002081B3, 32'h0,        0,   0, 0, 0,    32'h0000_0004, 32'd1,    4, 1, 0, 0, 0);
        issue(32'h00500093, 32'h0,        0,   2, 0, 1,    32'h0000_0008, 32'd2,    6, 1, 0, 0, 0);
        issue(32'h00208863, 32'h10,       0,   0, 0, 0,    32'h0000_000C, 32'd3,    3, 0, 0, 0, 0);
        issue(32'h00208863, 32'hFFFF_FFFC, 1,  0, 0, 0,    32'h0000_0008, 32'd4,    3, 0, 0, 0, 0);
        issue(32'h00208863, 32'h10,       1,   0, 0, 1,    32'h0000_0018, 32'd5,    3, 0, 0, 0, 0);
        issue(32'h0000A103, 32'h0,        0,   0, 3, 1,    32'h0000_001C, 32'd6,    8, 1, 4, 0, 0);
        issue(32'h0020A023, 32'h0,        0,   0, 0, 0,    32'h0000_0020, 32'd7,    4, 0, 1, 1, 0);
        issue(32'h0000007F, 32'h0,        0,   0, 0, 0,    32'h0000_0024, 32'd8,    3, 0, 0, 0, 1);
        issue(32'h00208863, 32'hFFFF_FFD8, 1,  0, 0, 0,    32'hFFFF_FFFC, 32'd9,    3, 0, 0, 0, 0);
        issue(32'h002081B3, 32'h0,        0,   0, 0, 0,    32'h0000_0000, 32'd10,   4, 1, 0, 0, 0);
        issue(32'h00208863, 32'h2,        1,   0, 0, 0,    32'h0000_0002, 32'd11,   3, 0, 0, 0, 0);
        issue(32'h0020A023, 32'h0,        0,   0, 2, 0,    32'h0000_0006, 32'd12,   6, 0, 3, 3, 0);
        issue(32'h00000037, 32'h0,        0,   0, 0, 0,    32'h0000_000A, 32'd13,   3, 0, 0, 0, 1);

        // Reset while a LOAD sits in MEM with dmem_valid arriving on the same edge.
        imem_rdata = 32'h0000A103;
        imem_valid = 1'b1;
        @(negedge clock);
        imem_valid = 1'b0;
        imem_rdata = JUNK;
        rfcnt      = 0;
        got_mem    = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rfcnt += rf_we ? 1 : 0;
            if (state == 3'd3) begin
                got_mem = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("reached_mem", 32'(got_mem), 32'd1);
        @(negedge clock);
        rfcnt += rf_we ? 1 : 0;
        reset      = 1'b1;
        dmem_valid = 1'b1;
        @(negedge clock);
        reset      = 1'b0;
        dmem_valid = 1'b0;
        rfcnt += rf_we ? 1 : 0;
        check_reset_outputs("midmem");
        chk("midmem_no_rf_we", 32'(rfcnt), 32'd0);

        issue(32'h002081B3, 32'h0,        0,   0, 0, 0,    32'h0000_0004, 32'd1,    4, 1, 0, 0, 0);

        repeat (2) @(negedge clock);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
